// File: rtl/culsans_pkg.sv
// Shared ACE-lite channel types and barrier FSM states for the culsans coherency path.
// Types only, no logic, so there is no latency.
// Backpressure lives in the modules that use these types.
package culsans_pkg;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 32;
  localparam int unsigned UserW = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [1:0]       bar;
    logic [UserW-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [1:0]       bar;
    logic [UserW-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
    logic [UserW-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [1:0]       resp;
    logic [UserW-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
    logic [UserW-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;

  // Write FSM uses the W_* members, read FSM the R_* members.
  typedef enum logic [2:0] {
    W_IDLE, W_DRAIN, W_RESP,
    R_IDLE, R_DRAIN, R_RESP
  } bar_state_e;

endpackage

// File: rtl/culsans_ostd_counter.sv
// Outstanding-transaction up/down counter with full and zero flags.
// Flags reflect the registered count, updated one cycle after inc/dec.
// No backpressure of its own; callers gate inc using full.
module culsans_ostd_counter #(
  parameter int unsigned Max = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero
);

  localparam int unsigned CntW = $clog2(Max + 1);

  logic [CntW-1:0] cnt;

  // Count issued minus retired; a simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign full = (cnt == CntW'(Max));
  assign zero = (cnt == '0);

endmodule

// File: rtl/culsans_bar_filter.sv
// Absorbs ACE barrier AW/AR: drains outstanding normal traffic, then answers locally.
// Normal traffic and W pass through combinationally; local B/R appear 2+ cycles after a barrier.
// Normal AW/AR stall at MaxOutstanding or while a barrier of the same direction is open.
module culsans_bar_filter
  import culsans_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i
);

  bar_state_e     wr_state, rd_state;
  logic [IdW-1:0] wr_bar_id, rd_bar_id;
  logic           wr_full, wr_zero, rd_full, rd_zero;
  logic           aw_is_bar, ar_is_bar;
  logic           wr_idle, wr_resp, rd_idle, rd_resp;
  logic           mst_aw_valid, mst_ar_valid, mst_b_ready, mst_r_ready;
  logic           wr_inc, wr_dec, rd_inc, rd_dec;
  logic           wr_room, rd_room;

  assign aw_is_bar = slv_req_i.aw.bar[0];
  assign ar_is_bar = slv_req_i.ar.bar[0];
  assign wr_idle   = (wr_state == W_IDLE);
  assign wr_resp   = (wr_state == W_RESP);
  assign rd_idle   = (rd_state == R_IDLE);
  assign rd_resp   = (rd_state == R_RESP);

  // While a local beat is offered the downstream channel is held off; it is empty anyway.
  assign mst_b_ready = slv_req_i.b_ready & ~wr_resp;
  assign mst_r_ready = slv_req_i.r_ready & ~rd_resp;
  assign wr_dec      = mst_resp_i.b_valid & mst_b_ready;
  assign rd_dec      = mst_resp_i.r_valid & mst_r_ready & mst_resp_i.r.last;

  // A retirement in the same cycle frees the slot, so a full counter does not stall.
  assign wr_room = ~wr_full | wr_dec;
  assign rd_room = ~rd_full | rd_dec;

  assign mst_aw_valid = slv_req_i.aw_valid & ~aw_is_bar & wr_idle & wr_room;
  assign mst_ar_valid = slv_req_i.ar_valid & ~ar_is_bar & rd_idle & rd_room;
  assign wr_inc       = mst_aw_valid & mst_resp_i.aw_ready;
  assign rd_inc       = mst_ar_valid & mst_resp_i.ar_ready;

  // Downstream request: everything copied, only the handshake bits are filtered.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = mst_aw_valid;
    mst_req_o.ar_valid = mst_ar_valid;
    mst_req_o.b_ready  = mst_b_ready;
    mst_req_o.r_ready  = mst_r_ready;
  end

  // Upstream response: pass-through unless a local barrier beat is being offered.
  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = wr_idle & (aw_is_bar | (wr_room & mst_resp_i.aw_ready));
    slv_resp_o.ar_ready = rd_idle & (ar_is_bar | (rd_room & mst_resp_i.ar_ready));
    if (wr_resp) begin
      slv_resp_o.b_valid = 1'b1;
      slv_resp_o.b.id    = wr_bar_id;
      slv_resp_o.b.resp  = RESP_OKAY;
      slv_resp_o.b.user  = '0;
    end
    if (rd_resp) begin
      slv_resp_o.r_valid = 1'b1;
      slv_resp_o.r.id    = rd_bar_id;
      slv_resp_o.r.data  = '0;
      slv_resp_o.r.resp  = RESP_OKAY;
      slv_resp_o.r.last  = 1'b1;
      slv_resp_o.r.user  = '0;
    end
  end

  // Write barrier: capture, wait for all downstream writes to retire, answer locally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state  <= W_IDLE;
      wr_bar_id <= '0;
    end else begin
      case (wr_state)
        W_IDLE:  if (slv_req_i.aw_valid && aw_is_bar) begin
                   wr_bar_id <= slv_req_i.aw.id;
                   wr_state  <= W_DRAIN;
                 end
        W_DRAIN: if (wr_zero) wr_state <= W_RESP;
        W_RESP:  if (slv_req_i.b_ready) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read barrier: same flow as writes, completion is the last R beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state  <= R_IDLE;
      rd_bar_id <= '0;
    end else begin
      case (rd_state)
        R_IDLE:  if (slv_req_i.ar_valid && ar_is_bar) begin
                   rd_bar_id <= slv_req_i.ar.id;
                   rd_state  <= R_DRAIN;
                 end
        R_DRAIN: if (rd_zero) rd_state <= R_RESP;
        R_RESP:  if (slv_req_i.r_ready) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  culsans_ostd_counter #(.Max(MaxOutstanding)) u_wr_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .inc  (wr_inc),
    .dec  (wr_dec),
    .full (wr_full),
    .zero (wr_zero)
  );

  culsans_ostd_counter #(.Max(MaxOutstanding)) u_rd_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .inc  (rd_inc),
    .dec  (rd_dec),
    .full (rd_full),
    .zero (rd_zero)
  );

endmodule

// File: tb/tb_culsans_bar_filter.sv
// Bench for culsans_bar_filter: directed barrier scenarios plus randomized traffic
// against a transaction-level model (outstanding counts and open-barrier bookkeeping).
module tb_culsans_bar_filter;
  import culsans_pkg::*;

  localparam int MAXO = 8;

  logic  clk = 1'b0;
  logic  rst;
  req_t  slv_req;
  resp_t slv_resp;
  req_t  mst_req;
  resp_t mst_resp;

  always #5 clk = ~clk;

  culsans_bar_filter #(.MaxOutstanding(MAXO)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding counts, whether a barrier is open, whether its reply is showing.
  int             m_wout = 0, m_rout = 0;
  bit             m_wpend = 0, m_rpend = 0, m_wresp = 0, m_rresp = 0;
  logic [IdW-1:0] m_wid = '0, m_rid = '0;

  logic    e_awv, e_awr, e_arv, e_arr, e_bv, e_rv, e_brdy, e_rrdy, bdec, rdec;
  b_chan_t e_b;
  r_chan_t e_r;
  int      old_w, old_r;

  // Compare outputs against the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    e_brdy = slv_req.b_ready && !m_wresp;
    e_rrdy = slv_req.r_ready && !m_rresp;
    bdec   = mst_resp.b_valid && e_brdy;
    rdec   = mst_resp.r_valid && mst_resp.r.last && e_rrdy;
    e_awv  = slv_req.aw_valid && !slv_req.aw.bar[0] && !m_wpend && (m_wout < MAXO || bdec);
    e_arv  = slv_req.ar_valid && !slv_req.ar.bar[0] && !m_rpend && (m_rout < MAXO || rdec);
    e_awr  = !m_wpend && (slv_req.aw.bar[0] || ((m_wout < MAXO || bdec) && mst_resp.aw_ready));
    e_arr  = !m_rpend && (slv_req.ar.bar[0] || ((m_rout < MAXO || rdec) && mst_resp.ar_ready));
    e_bv   = m_wresp ? 1'b1 : mst_resp.b_valid;
    e_rv   = m_rresp ? 1'b1 : mst_resp.r_valid;
    e_b    = m_wresp ? '{id: m_wid, resp: 2'b00, user: '0} : mst_resp.b;
    e_r    = m_rresp ? '{id: m_rid, data: '0, resp: 2'b00, last: 1'b1, user: '0} : mst_resp.r;

    chk("mst_aw_valid", 64'(mst_req.aw_valid), 64'(e_awv));
    chk("slv_aw_ready", 64'(slv_resp.aw_ready), 64'(e_awr));
    chk("mst_ar_valid", 64'(mst_req.ar_valid), 64'(e_arv));
    chk("slv_ar_ready", 64'(slv_resp.ar_ready), 64'(e_arr));
    if (e_awv) chk("mst_aw_payload", 64'(mst_req.aw), 64'(slv_req.aw));
    if (e_arv) chk("mst_ar_payload", 64'(mst_req.ar), 64'(slv_req.ar));
    chk("mst_w_valid", 64'(mst_req.w_valid), 64'(slv_req.w_valid));
    chk("mst_w_payload", 64'(mst_req.w), 64'(slv_req.w));
    chk("slv_w_ready", 64'(slv_resp.w_ready), 64'(mst_resp.w_ready));
    chk("mst_b_ready", 64'(mst_req.b_ready), 64'(e_brdy));
    chk("mst_r_ready", 64'(mst_req.r_ready), 64'(e_rrdy));
    chk("slv_b_valid", 64'(slv_resp.b_valid), 64'(e_bv));
    chk("slv_r_valid", 64'(slv_resp.r_valid), 64'(e_rv));
    if (e_bv) chk("slv_b_payload", 64'(slv_resp.b), 64'(e_b));
    if (e_rv) chk("slv_r_payload", 64'(slv_resp.r), 64'(e_r));
    chk("wr_cnt", 64'(dut.u_wr_cnt.cnt), 64'(m_wout));
    chk("rd_cnt", 64'(dut.u_rd_cnt.cnt), 64'(m_rout));

    old_w = m_wout;
    old_r = m_rout;
    if (rst) begin
      m_wout = 0; m_rout = 0;
      m_wpend = 0; m_rpend = 0; m_wresp = 0; m_rresp = 0;
      m_wid = '0; m_rid = '0;
    end else begin
      m_wout = m_wout + int'(e_awv && mst_resp.aw_ready) - int'(bdec);
      m_rout = m_rout + int'(e_arv && mst_resp.ar_ready) - int'(rdec);
      // A barrier reply shows once the barrier has been open for a cycle with nothing outstanding.
      if (m_wresp) begin
        if (slv_req.b_ready) begin m_wpend = 0; m_wresp = 0; end
      end else if (m_wpend) begin
        if (old_w == 0) m_wresp = 1;
      end else if (slv_req.aw_valid && slv_req.aw.bar[0]) begin
        m_wpend = 1; m_wid = slv_req.aw.id;
      end
      if (m_rresp) begin
        if (slv_req.r_ready) begin m_rpend = 0; m_rresp = 0; end
      end else if (m_rpend) begin
        if (old_r == 0) m_rresp = 1;
      end else if (slv_req.ar_valid && slv_req.ar.bar[0]) begin
        m_rpend = 1; m_rid = slv_req.ar.id;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    slv_req           = '0;
    slv_req.b_ready   = 1'b1;
    slv_req.r_ready   = 1'b1;
    mst_resp          = '0;
    mst_resp.aw_ready = 1'b1;
    mst_resp.ar_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
  endtask

  bit [127:0] rnd;

  initial begin
    rst = 1'b1;
    quiet();
    tick();
    tick();
    rst = 1'b0;

    // S1: lone write barrier id=3 answered two cycles after acceptance, never forwarded.
    quiet();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd3; slv_req.aw.bar = 2'b01;
    #1;
    chk("s1_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
    chk("s1_no_mst_aw", 64'(mst_req.aw_valid), 64'd0);
    tick();
    quiet();
    #1 chk("s1_b_early", 64'(slv_resp.b_valid), 64'd0);
    tick();
    #1;
    chk("s1_b_valid", 64'(slv_resp.b_valid), 64'd1);
    chk("s1_b_id", 64'(slv_resp.b.id), 64'd3);
    chk("s1_b_resp", 64'(slv_resp.b.resp), 64'd0);
    tick();
    #1 chk("s1_b_done", 64'(slv_resp.b_valid), 64'd0);

    // S2: two writes outstanding, then read barrier id=5 and write barrier id=7 together.
    quiet();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd1;
    tick();
    slv_req.aw.id = 4'd2;
    tick();
    quiet();
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd5; slv_req.ar.bar = 2'b01;
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd7; slv_req.aw.bar = 2'b01;
    #1;
    chk("s2_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
    chk("s2_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
    tick();
    quiet();
    #1 chk("s2_r_early", 64'(slv_resp.r_valid), 64'd0);
    tick();
    #1;
    chk("s2_r_valid", 64'(slv_resp.r_valid), 64'd1);
    chk("s2_r_id", 64'(slv_resp.r.id), 64'd5);
    chk("s2_r_last", 64'(slv_resp.r.last), 64'd1);
    chk("s2_r_data", 64'(slv_resp.r.data), 64'd0);
    chk("s2_b_held", 64'(slv_resp.b_valid), 64'd0);
    tick();
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd1;
    #1 chk("s2_b_pass_id", 64'(slv_resp.b.id), 64'd1);
    tick();
    mst_resp.b.id = 4'd2;
    tick();
    quiet();
    #1 chk("s2_b_wait", 64'(slv_resp.b_valid), 64'd0);
    tick();
    #1;
    chk("s2_b_valid", 64'(slv_resp.b_valid), 64'd1);
    chk("s2_b_id", 64'(slv_resp.b.id), 64'd7);
    tick();

    // S3: eight reads fill the window; the ninth waits, then goes out with a last R.
    for (int i = 0; i < 8; i++) begin
      quiet();
      slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'(i);
      tick();
    end
    quiet();
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd8;
    #1;
    chk("s3_stall_mst", 64'(mst_req.ar_valid), 64'd0);
    chk("s3_stall_slv", 64'(slv_resp.ar_ready), 64'd0);
    tick();
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
    #1;
    chk("s3_fwd_mst", 64'(mst_req.ar_valid), 64'd1);
    chk("s3_fwd_slv", 64'(slv_resp.ar_ready), 64'd1);
    tick();
    quiet();
    #1 chk("s3_rd_cnt", 64'(dut.u_rd_cnt.cnt), 64'd8);
    for (int i = 0; i < 8; i++) begin
      mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1;
      tick();
    end
    quiet();

    // S4: with four writes outstanding, an AW and a B in one cycle leave the count at 4.
    for (int i = 0; i < 4; i++) begin
      quiet();
      slv_req.aw_valid = 1'b1;
      tick();
    end
    quiet();
    slv_req.aw_valid = 1'b1; mst_resp.b_valid = 1'b1;
    #1 chk("s4_cnt_before", 64'(dut.u_wr_cnt.cnt), 64'd4);
    tick();
    quiet();
    #1 chk("s4_cnt_after", 64'(dut.u_wr_cnt.cnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      mst_resp.b_valid = 1'b1;
      tick();
    end
    quiet();

    // S5: local B held for five cycles of b_ready=0; a normal AW waits until it is taken.
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd9; slv_req.aw.bar = 2'b01;
    tick();
    quiet();
    slv_req.b_ready = 1'b0;
    tick();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd1; slv_req.aw.bar = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s5_b_valid", 64'(slv_resp.b_valid), 64'd1);
      chk("s5_b_id", 64'(slv_resp.b.id), 64'd9);
      chk("s5_aw_blocked", 64'(mst_req.aw_valid), 64'd0);
      chk("s5_aw_ready", 64'(slv_resp.aw_ready), 64'd0);
      tick();
    end
    slv_req.b_ready = 1'b1;
    #1 chk("s5_aw_still_blocked", 64'(mst_req.aw_valid), 64'd0);
    tick();
    #1 chk("s5_aw_fwd", 64'(mst_req.aw_valid), 64'd1);
    tick();
    quiet();
    mst_resp.b_valid = 1'b1;
    tick();
    quiet();

    // S6: reset while draining drops the barrier and the count; no B afterwards.
    slv_req.aw_valid = 1'b1;
    tick();
    quiet();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd4; slv_req.aw.bar = 2'b01;
    tick();
    quiet();
    #1 chk("s6_cnt_pre", 64'(dut.u_wr_cnt.cnt), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("s6_cnt", 64'(dut.u_wr_cnt.cnt), 64'd0);
    chk("s6_state", 64'(dut.wr_state), 64'(W_IDLE));
    for (int i = 0; i < 5; i++) begin
      tick();
      #1 chk("s6_no_b", 64'(slv_resp.b_valid), 64'd0);
    end

    // Randomized traffic; B and last-R only offered while the model has something outstanding.
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      slv_req = req_t'(rnd[$bits(req_t)-1:0]);
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      mst_resp = resp_t'(rnd[$bits(resp_t)-1:0]);
      slv_req.aw.bar[0] = ($urandom_range(0, 5) == 0);
      slv_req.ar.bar[0] = ($urandom_range(0, 5) == 0);
      slv_req.b_ready   = ($urandom_range(0, 3) != 0);
      slv_req.r_ready   = ($urandom_range(0, 3) != 0);
      mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
      mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
      mst_resp.b_valid  = (m_wout > 0) && ($urandom_range(0, 2) == 0);
      mst_resp.r_valid  = (m_rout > 0) && ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    quiet();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
